sensor_packetizer: RTL and testbench
====================================

SENSOR_PACKETIZER -- requirements
Module: sensor_packetizer

Interface
REQ-001 SHALL have parameter SENSORS, default 1, number of sensors; the payload holds 2*SENSORS words.
REQ-002 SHALL have parameter BITWIDTH, default 32, width of one data word; legal values are multiples of 8 in the range 8..64.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sensor_data  input  2*SENSORS*BITWIDTH  packed words from the sensor controller; word i occupies bits [(i+1)*BITWIDTH-1 : i*BITWIDTH].
REQ-006 SHALL have port sensor_done  input  1  upstream data valid.
REQ-007 SHALL have port sensor_ack  output  1  one-cycle pulse asserted when a snapshot is captured.
REQ-008 SHALL have port enable  input  1  permits the start of a new packet.
REQ-009 SHALL have port tx_data  output  8  outgoing byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-011 SHALL have port tx_ready  input  1  the sink accepts the byte when tx_valid and tx_ready are both high.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL use the states IDLE, HEADER, SEQ, PAYLOAD and CHECKSUM.
REQ-014 In IDLE with enable=1 and sensor_done=1, the block SHALL, in the same cycle, register sensor_data into a snapshot and assert sensor_ack for exactly one cycle; the next state is HEADER.
REQ-015 The packet byte order SHALL be:
- 0xA5
- sequence byte
- payload: word 0 first, each word little-endian; payload length N = 2*SENSORS*BITWIDTH/8 bytes
- checksum
REQ-016 The checksum SHALL be the 8-bit sum, modulo 256, of the sequence byte and all payload bytes; the header is excluded.
REQ-017 tx_valid SHALL be high in HEADER, SEQ, PAYLOAD and CHECKSUM, and low in IDLE.
REQ-018 A state or byte index SHALL advance only on a tx_valid and tx_ready handshake.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable.
REQ-020 The first tx_valid=1 SHALL occur the cycle after the sensor_ack pulse.
REQ-021 With tx_ready held at 1, a packet SHALL take exactly N+3 consecutive cycles.
REQ-022 The payload byte counter SHALL count from 0 to N-1; when byte N-1 is accepted, the state SHALL go to CHECKSUM.
REQ-023 When the checksum byte is accepted, the state SHALL return to IDLE and the sequence number SHALL increment; it wraps from 0xFF to 0x00.
REQ-024 The earliest next capture SHALL be the cycle after the state returns to IDLE, so at least one idle cycle separates packets.
REQ-025 While the state is not IDLE, sensor_done SHALL be ignored: no sensor_ack is issued, and changes on sensor_data do not affect the packet in flight.
REQ-026 Deasserting enable mid-packet SHALL NOT abort the packet; it only blocks the next capture.
REQ-027 With enable=0 or sensor_done=0 in IDLE, the block SHALL remain in IDLE with sensor_ack=0.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set:
- state to IDLE
- tx_valid=0, sensor_ack=0, busy=0, tx_data=0x00
- sequence number, byte counter, checksum and snapshot to 0
REQ-029 Reset mid-packet SHALL abandon the packet: tx_valid is 0 from the first edge with rst=1, and the next packet after reset uses sequence 0x00.

Structure
REQ-030 The state enumeration and the header constant 0xA5 SHALL reside in the shared package sensor_pkg.
REQ-031 Checksum accumulation SHALL be a sub-module packet_checksum with clear, add-on-strobe and 8-bit sum output.
REQ-032 The byte counter width SHALL be clog2(N) bits, with a minimum of 1.

Verification (SENSORS=1, BITWIDTH=32, N=8)
REQ-033 Reset: hold rst=1 for 2 cycles -> tx_valid=0, sensor_ack=0, busy=0; the first packet carries sequence 0x00.
REQ-034 Basic packet: word0=0x00000001, word1=0x0000000F, sensor_done=1, enable=1, tx_ready=1 -> one ack pulse, then the stream A5 00 01 00 00 00 0F 00 00 00 10 over 11 consecutive cycles.
REQ-035 Backpressure: tx_ready=0 for 3 cycles while payload byte 2 is presented -> tx_data holds the same value, and the stream contains no loss and no duplication.
REQ-036 Upstream hold: sensor_done held at 1 and sensor_data changed during transmission -> exactly one ack per packet, the payload matches the captured snapshot, and the next ack comes no earlier than 1 cycle after the return to IDLE.
REQ-037 Sequence wrap: send 257 back-to-back packets -> the sequence bytes run 0x00..0xFF, then 0x00.
REQ-038 Reset mid-payload at byte 4 -> tx_valid=0 from the first edge with rst=1, and the next packet starts with A5 00.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor packetizer.
// Packet framing: A5, sequence, payload, checksum.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SEQ,
    PAYLOAD,
    CHECKSUM
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packet_checksum.sv
// Running 8-bit modulo-256 sum of packet bytes.
// Cleared at capture, accumulates on each strobe.
module packet_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sensor_packetizer.sv
// Captures a sensor snapshot and streams it as a framed
// byte packet over a valid/ready link.
module sensor_packetizer
  import sensor_pkg::*;
#(
  parameter int SENSORS  = 1,
  parameter int BITWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*SENSORS*BITWIDTH-1:0] sensor_data,
  input  logic                          sensor_done,
  output logic                          sensor_ack,
  input  logic                          enable,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy
);

  localparam int SW = 2 * SENSORS * BITWIDTH;
  localparam int N  = SW / 8;
  localparam int CW = cnt_width(N);

  state_e        state_q, state_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [SW-1:0] snap_sh;
  logic [7:0]    seq_q, seq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sum;
  logic          capture;
  logic          fire;
  logic          last;
  logic          add;

  assign capture = (state_q == IDLE) && enable
                && sensor_done && !rst;
  assign tx_valid = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign fire     = tx_valid && tx_ready;
  assign last     = (cnt_q == CW'(N - 1));
  assign snap_sh  = snap_q >> {cnt_q, 3'b000};
  assign add      = fire && ((state_q == SEQ)
                || (state_q == PAYLOAD));
  assign sensor_ack = capture;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    tx_data = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          snap_d  = sensor_data;
          cnt_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        tx_data = HDR_BYTE;
        if (fire) state_d = SEQ;
      end
      SEQ: begin
        tx_data = seq_q;
        if (fire) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        tx_data = snap_sh[7:0];
        if (fire) begin
          if (last) begin
            cnt_d   = '0;
            state_d = CHECKSUM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHECKSUM: begin
        tx_data = sum;
        if (fire) begin
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      seq_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sum covers the sequence byte and payload only.
  packet_checksum u_csum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (capture),
    .add_i   (add),
    .data_i  (tx_data),
    .sum_o   (sum)
  );

endmodule

// File: tb/tb_sensor_packetizer.sv
// Self-checking bench for sensor_packetizer with a
// queue-based packet model (SENSORS=1, BITWIDTH=32).
module tb_sensor_packetizer;

  localparam int SW = 64;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sensor_data;
  logic          sensor_done;
  logic          sensor_ack;
  logic          enable;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;

  sensor_packetizer #(.SENSORS(1), .BITWIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_data (sensor_data),
    .sensor_done (sensor_done),
    .sensor_ack  (sensor_ack),
    .enable      (enable),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  byte unsigned mq[$];
  logic [7:0]   mseq = 8'h00;
  int           m_started = 0;

  byte unsigned rxlog[$];
  int           rxcyc[$];
  byte unsigned seqlog[$];
  int           pos = 100;
  int           acks = 0;
  int           cyc = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected packet straight from the framing rules.
  task automatic build(input logic [SW-1:0] d);
    logic [7:0] s;
    s = mseq;
    mq.push_back(8'hA5);
    mq.push_back(mseq);
    for (int k = 0; k < N; k++) begin
      mq.push_back(d[8*k +: 8]);
      s = s + d[8*k +: 8];
    end
    mq.push_back(s);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready && !rst) begin
      rxlog.push_back(tx_data);
      rxcyc.push_back(cyc);
      if (pos == 1) seqlog.push_back(tx_data);
      pos++;
    end
    if (sensor_ack) begin
      acks++;
      pos = 0;
    end
    if (rst) begin
      mq.delete();
      mseq = 8'h00;
    end else if (mq.size() == 0) begin
      if (enable && sensor_done) begin
        build(sensor_data);
        m_started++;
      end
    end else if (tx_ready) begin
      void'(mq.pop_front());
      if (mq.size() == 0) mseq = mseq + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", sensor_ack,
            !rst && mq.size() == 0 && enable && sensor_done);
      check("valid", tx_valid, mq.size() != 0);
      check("busy", busy, mq.size() != 0);
      if (mq.size() != 0) check("data", tx_data, mq[0]);
    end
  end

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((mq.size() != 0 || tx_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({nm, "_timeout"}, t < 300, 1'b1);
  endtask

  task automatic one_packet(input logic [SW-1:0] d);
    sensor_data = d;
    enable = 1'b1;
    sensor_done = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    sensor_done = 1'b0;
  endtask

  byte unsigned exp_basic[11] = '{8'hA5, 8'h00, 8'h01, 8'h00,
    8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h10};
  byte unsigned exp_bp[11] = '{8'hA5, 8'h01, 8'h11, 8'h22,
    8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};

  initial begin
    int t;
    rst = 1'b1;
    enable = 1'b0;
    sensor_done = 1'b0;
    tx_ready = 1'b1;
    sensor_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_ack", sensor_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", tx_data, 8'h00);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic packet
    rxlog.delete();
    rxcyc.delete();
    acks = 0;
    one_packet({32'h0000000F, 32'h00000001});
    check("basic_ack", acks, 1);
    wait_idle("basic");
    check("basic_len", rxlog.size(), 11);
    for (int k = 0; k < rxlog.size() && k < 11; k++)
      check("basic_byte", rxlog[k], exp_basic[k]);
    if (rxcyc.size() == 11)
      check("basic_span", rxcyc[10] - rxcyc[0], 10);

    // backpressure on payload byte 2
    rxlog.delete();
    one_packet({32'h88776655, 32'h44332211});
    repeat (4) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", tx_data, 8'h33);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle("bp");
    check("bp_len", rxlog.size(), 11);
    for (int k = 0; k < rxlog.size() && k < 11; k++)
      check("bp_byte", rxlog[k], exp_bp[k]);

    // upstream held high, data churning
    acks = 0;
    m_started = 0;
    enable = 1'b1;
    sensor_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      sensor_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sensor_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    wait_idle("hold");
    check("hold_acks", acks, m_started);
    check("hold_acks_lit", acks, 4);

    // sequence wrap over 257 packets
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seqlog.delete();
    acks = 0;
    sensor_data = 64'h0123456789ABCDEF;
    enable = 1'b1;
    sensor_done = 1'b1;
    t = 0;
    while (acks < 257 && t < 4000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wrap_timeout", t < 4000, 1'b1);
    enable = 1'b0;
    sensor_done = 1'b0;
    wait_idle("wrap");
    check("wrap_count", seqlog.size(), 257);
    for (int i = 0; i < seqlog.size(); i++)
      check("wrap_seq", seqlog[i], i[7:0]);

    // reset in the middle of payload byte 4
    one_packet({32'h08070605, 32'h04030201});
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_valid_pre", tx_valid, 1'b1);
    check("mid_data_pre", tx_data, 8'h05);
    @(posedge clk);
    @(negedge clk);
    check("mid_valid_rst", tx_valid, 1'b0);
    check("mid_busy_rst", busy, 1'b0);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rxlog.delete();
    one_packet({32'h0000000F, 32'h00000001});
    wait_idle("post");
    check("post_len", rxlog.size(), 11);
    if (rxlog.size() >= 2) begin
      check("post_hdr", rxlog[0], 8'hA5);
      check("post_seq", rxlog[1], 8'h00);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
